jet_phi_cluster: RTL

Parametrised L2 phi clusterer: consumes one eta-slice's NPHI phi bins (pT, track count, special-track count) as a stream at one bin per accepted beat. It finds local-maximum jet centres and emits each jet as a 3-bin sum with saturated fields. It sits after the L1 eta clusterer and replaces the fixed-27-bin greedy L2 stage. Optional circular-phi handling is included.

---
 rtl/jet_phi_pkg.sv | 19 +
 rtl/jet_phi_cluster_sum.sv | 39 +++
 rtl/jet_phi_cluster.sv | 104 ++++++++++
 3 files changed

// File: rtl/jet_phi_pkg.sv
// jet_phi_pkg: shared types and helpers for the L2 phi clusterer.
package jet_phi_pkg;
   localparam int DEF_PT_W = 9, DEF_NT_W = 5, DEF_NX_W = 4, DEF_PHI_W = 5;
   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
   typedef struct packed {
      logic [DEF_NX_W-1:0] nx;
      logic [DEF_NT_W-1:0] nt;
      logic [DEF_PT_W-1:0] pt;
   } bin_t;
   typedef struct packed {
      logic [DEF_NT_W-1:0]  nt;
      logic [DEF_NX_W-1:0]  nx;
      logic [DEF_PHI_W-1:0] phi;
      logic [DEF_PT_W-1:0]  pt;
   } jet_t;
   function automatic logic [31:0] sat_u(input logic [31:0] s, input int w);
      return (s >> w) != 0 ? (32'd1 << w) - 32'd1 : s;
   endfunction
endpackage

// File: rtl/jet_phi_cluster_sum.sv
// jet_phi_sum: sums a 3-bin window into a saturated jet word and registers it.
module jet_phi_sum
   import jet_phi_pkg::*;
#(
   parameter int PT_W = 9, NT_W = 5, NX_W = 4, PHI_W = 5
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            centre,
   input  logic                            left_claimed,
   input  logic [NX_W+NT_W+PT_W-1:0]       l_bin,
   input  logic [NX_W+NT_W+PT_W-1:0]       m_bin,
   input  logic [NX_W+NT_W+PT_W-1:0]       r_bin,
   input  logic [PHI_W-1:0]                phi,
   output logic [NT_W+NX_W+PHI_W+PT_W-1:0] jet,
   output logic                            jet_valid
);
   localparam int BW = NX_W + NT_W + PT_W;
   logic [BW-1:0]     l;
   logic [PT_W+1:0]   pt_s;
   logic [NT_W+1:0]   nt_s;
   logic [NX_W+1:0]   nx_s;
   assign l = left_claimed ? '0 : l_bin;
   assign pt_s = (PT_W+2)'(l[PT_W-1:0]) + (PT_W+2)'(m_bin[PT_W-1:0]) + (PT_W+2)'(r_bin[PT_W-1:0]);
   assign nt_s = (NT_W+2)'(l[PT_W +: NT_W]) + (NT_W+2)'(m_bin[PT_W +: NT_W]) + (NT_W+2)'(r_bin[PT_W +: NT_W]);
   assign nx_s = (NX_W+2)'(l[PT_W+NT_W +: NX_W]) + (NX_W+2)'(m_bin[PT_W+NT_W +: NX_W])
               + (NX_W+2)'(r_bin[PT_W+NT_W +: NX_W]);
   always_ff @(posedge clk) begin
      if (reset) begin
         jet       <= '0;
         jet_valid <= 1'b0;
      end else begin
         jet_valid <= centre;
         if (centre)
            jet <= {NT_W'(sat_u(32'(nt_s), NT_W)), NX_W'(sat_u(32'(nx_s), NX_W)), phi,
                    PT_W'(sat_u(32'(pt_s), PT_W))};
      end
   end
endmodule

// File: rtl/jet_phi_cluster.sv
// jet_phi_cluster: streaming local-maximum phi clusterer emitting 3-bin jets.
// Define JET_PHI_WRAP_EN for circular phi (bins 0..2 replayed after the last bin).
module jet_phi_cluster
   import jet_phi_pkg::*;
#(
   parameter int NPHI   = 27,
   parameter int PT_W   = 9,
   parameter int NT_W   = 5,
   parameter int NX_W   = 4,
   parameter int MIN_PT = 1,
   parameter int PHI_W  = $clog2(NPHI)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic                            in_last,
   input  logic [PT_W-1:0]                 in_pt,
   input  logic [NT_W-1:0]                 in_nt,
   input  logic [NX_W-1:0]                 in_nx,
   output logic [NT_W+NX_W+PHI_W+PT_W-1:0] jet,
   output logic                            jet_valid,
   output logic                            done,
   output logic                            err
);
   localparam int BW = NX_W + NT_W + PT_W;
`ifdef JET_PHI_WRAP_EN
   localparam int F = 3, EV_MIN = 3;
`else
   localparam int F = 1, EV_MIN = 1;
`endif
   state_t           state;
   logic [PHI_W-1:0] k, cphi;
   logic [1:0]       f;
   logic [BW-1:0]    p1, p2, x, din;
   logic             h1, h2, acc, step, is_c, k_last, f_last;
   assign din      = {in_nx, in_nt, in_pt};
   assign in_ready = state != FLUSH;
   assign acc      = in_valid && in_ready;
   assign step     = acc || state == FLUSH;
   assign k_last   = k == PHI_W'(NPHI - 1);
   assign f_last   = f == 2'(F - 1);
`ifdef JET_PHI_WRAP_EN
   logic [BW-1:0] s [3];
   always_ff @(posedge clk)
      if (acc && k < PHI_W'(3)) s[k[1:0]] <= din;
   assign x = state == FLUSH ? s[f] : din;
`else
   assign x = state == FLUSH ? '0 : din;
`endif
   // p1 holds the candidate centre, p2 its left neighbour, x the incoming right neighbour
   assign cphi = state == FLUSH ? (f == 2'd0 ? PHI_W'(NPHI - 1) : PHI_W'(f - 2'd1)) : k - PHI_W'(1);
   assign is_c = step && (state == FLUSH || int'(k) >= EV_MIN) && int'(p1[PT_W-1:0]) >= MIN_PT
              && p1[PT_W-1:0] > p2[PT_W-1:0] && p1[PT_W-1:0] >= x[PT_W-1:0];
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         k     <= '0;
         f     <= '0;
         p1    <= '0;
         p2    <= '0;
         h1    <= 1'b0;
         h2    <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= acc && (in_last != k_last);
         if (step) begin
            p2 <= p1;
            p1 <= x;
            h2 <= h1;
            h1 <= is_c;
         end
         if (acc) begin
            state <= k_last ? FLUSH : RUN;
            k     <= k_last ? '0 : k + PHI_W'(1);
         end
         if (state == FLUSH) begin
            f <= f_last ? 2'd0 : f + 2'd1;
            if (f_last) begin
               state <= IDLE;
               done  <= 1'b1;
               p1    <= '0;
               p2    <= '0;
               h1    <= 1'b0;
               h2    <= 1'b0;
            end
         end
      end
   end
   jet_phi_sum #(.PT_W(PT_W), .NT_W(NT_W), .NX_W(NX_W), .PHI_W(PHI_W)) u_sum (
      .clk         (clk),
      .reset       (reset),
      .centre      (is_c),
      .left_claimed(h2),
      .l_bin       (p2),
      .m_bin       (p1),
      .r_bin       (x),
      .phi         (cphi),
      .jet         (jet),
      .jet_valid   (jet_valid)
   );
endmodule
